// File: rtl/fp_conv_pkg.sv
// Shared types and constants for the sequenced 12-bit to floating-point converter.
package fp_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_IN_W  = 12;
  localparam int DEF_EXP_W = 3;
  localparam int DEF_SIG_W = 4;

  localparam logic [DEF_EXP_W-1:0] EXP_MAX = 3'd7;
  localparam logic [DEF_SIG_W-1:0] SIG_MAX = 4'd15;
  localparam logic [DEF_IN_W-1:0]  MIN_NEG = 12'h800;

  // Magnitude of a two's-complement sample; MIN_NEG wraps to zero and is flagged separately.
  function automatic logic [DEF_IN_W-2:0] mag_of(input logic [DEF_IN_W-1:0] d);
    logic [DEF_IN_W-1:0] n;
    n = d[DEF_IN_W-1] ? (~d + 1'b1) : d;
    return n[DEF_IN_W-2:0];
  endfunction

endpackage

// File: rtl/fp_seq_converter_if.sv
// Sample-in / result-out handshake bundle for fp_seq_converter.
interface fp_seq_converter_if #(
  parameter int IN_W  = fp_conv_pkg::DEF_IN_W,
  parameter int EXP_W = fp_conv_pkg::DEF_EXP_W,
  parameter int SIG_W = fp_conv_pkg::DEF_SIG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  D;
  logic             out_valid;
  logic             out_ready;
  logic             S;
  logic [EXP_W-1:0] E;
  logic [SIG_W-1:0] F;
  logic             sat;
  logic             busy;

  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, S, E, F, sat, busy
  );

  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, S, E, F, sat, busy
  );
endinterface

// File: rtl/fp_seq_converter_round.sv
// Rounds a normalised significand on its first dropped bit and clamps on overflow.
// Purely combinational; no handshake.
module fp_round
  import fp_conv_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int SIG_W = DEF_SIG_W
) (
  input  logic [SIG_W-1:0] f,
  input  logic             fifth,
  input  logic [EXP_W-1:0] exp,
  input  logic             ovf,
  output logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F,
  output logic             sat
);

  localparam logic [SIG_W-1:0] SIG_HALF = {1'b1, {(SIG_W-1){1'b0}}};

  always_comb begin
    E   = exp;
    F   = f + SIG_W'(fifth);
    sat = 1'b0;
    if (ovf) begin
      E   = EXP_MAX;
      F   = SIG_MAX;
      sat = 1'b1;
    end else if (fifth && (f == SIG_MAX)) begin
      // Rounding carried out of the significand: renormalise, or clamp if already at the top.
      if (exp == EXP_MAX) begin
        E   = EXP_MAX;
        F   = SIG_MAX;
        sat = 1'b1;
      end else begin
        E = exp + EXP_W'(1);
        F = SIG_HALF;
      end
    end
  end

endmodule

// File: rtl/fp_seq_converter.sv
// Serial normalise/round converter from a two's-complement sample to S/E/F float.
// Latency k+2 clk after accept (k = shift count); result held until out_ready, no input accepted meanwhile.
module fp_seq_converter
  import fp_conv_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int EXP_W = DEF_EXP_W,
  parameter int SIG_W = DEF_SIG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_seq_converter_if.slave   bus
);

  state_t           state;
  logic             sign;
  logic [IN_W-2:0]  mag;
  logic [EXP_W-1:0] exp;
  logic             ovf;

  logic             in_ready_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             s_q;
  logic [EXP_W-1:0] e_q;
  logic [SIG_W-1:0] f_q;
  logic             sat_q;

  logic [SIG_W-1:0] rnd_f;
  logic             rnd_fifth;
  logic [EXP_W-1:0] rnd_e;
  logic [SIG_W-1:0] rnd_sig;
  logic             rnd_sat;

  assign rnd_f     = mag[IN_W-2 -: SIG_W];
  assign rnd_fifth = mag[IN_W-2-SIG_W] & (exp != '0);

  fp_round #(
    .EXP_W (EXP_W),
    .SIG_W (SIG_W)
  ) u_round (
    .f     (rnd_f),
    .fifth (rnd_fifth),
    .exp   (exp),
    .ovf   (ovf),
    .E     (rnd_e),
    .F     (rnd_sig),
    .sat   (rnd_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sign        <= 1'b0;
      mag         <= '0;
      exp         <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= 1'b0;
      e_q         <= '0;
      f_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign       <= bus.D[IN_W-1];
            mag        <= mag_of(bus.D);
            exp        <= EXP_MAX;
            ovf        <= (bus.D == MIN_NEG);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= NORM;
          end
        end
        NORM: begin
          // exp==0 is tested before decrementing, so exp cannot wrap.
          if (ovf || mag[IN_W-2] || (exp == '0)) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            exp <= exp - EXP_W'(1);
          end
        end
        ROUND: begin
          s_q         <= sign;
          e_q         <= rnd_e;
          f_q         <= rnd_sig;
          sat_q       <= rnd_sat;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.E         = e_q;
  assign bus.F         = f_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_fp_seq_converter.sv
// Bench for fp_seq_converter: directed table, backpressure/reset sequences, random vs. arithmetic model.
module tb_fp_seq_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int o_s, o_e, o_f, o_sat;

  fp_seq_converter_if bus ();

  fp_seq_converter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    int          s, e, f, sat, lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Value-level model: pick the exponent from the magnitude's leading-one position,
  // round half-up on the next lower bit, clamp at 15*2^7.
  function automatic void model(input logic [11:0] d, output int s, output int e,
                                output int f, output int sat, output int lat);
    int v, p, rb;
    if (d == 12'h800) begin
      s = 1; e = 7; f = 15; sat = 1; lat = 2;
      return;
    end
    s = int'(d[11]);
    v = d[11] ? 4096 - int'(d) : int'(d);
    p = -1;
    for (int i = 0; i < 11; i++) if (v >= (1 << i)) p = i;
    e   = (p > 3) ? p - 3 : 0;
    f   = v >> e;
    rb  = (e > 0) ? ((v >> (e - 1)) & 1) : 0;
    lat = (7 - e) + 2;
    sat = 0;
    f   = f + rb;
    if (f == 16) begin
      if (e == 7) begin
        f = 15; sat = 1;
      end else begin
        f = 8; e = e + 1;
      end
    end
  endfunction

  task automatic run_txn(input logic [11:0] d, input int hold, input bit pulse, output int lat);
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.D = d;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.D = 12'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
    o_s = int'(bus.S); o_e = int'(bus.E); o_f = int'(bus.F); o_sat = int'(bus.sat);
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 0) begin
        bus.D = 12'h123;
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_busy", int'(bus.busy), 1);
      chk("hold_stable", int'({bus.S, bus.E, bus.F, bus.sat}),
          (o_s << 8) | (o_e << 5) | (o_f << 1) | o_sat);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_valid", int'(bus.out_valid), 0);
    chk("release_in_ready", int'(bus.in_ready), 1);
    chk("release_busy", int'(bus.busy), 0);
  endtask

  initial begin
    int lat, s, e, f, sat;
    logic [11:0] d;

    vecs[0] = '{d: 12'h1A6, s: 0, e: 5, f: 13, sat: 0, lat: 4};
    vecs[1] = '{d: 12'hFC8, s: 1, e: 2, f: 14, sat: 0, lat: 7};
    vecs[2] = '{d: 12'h000, s: 0, e: 0, f: 0,  sat: 0, lat: 9};
    vecs[3] = '{d: 12'h3FF, s: 0, e: 7, f: 8,  sat: 0, lat: 3};
    vecs[4] = '{d: 12'h7FF, s: 0, e: 7, f: 15, sat: 1, lat: 2};
    vecs[5] = '{d: 12'h800, s: 1, e: 7, f: 15, sat: 1, lat: 2};
    vecs[6] = '{d: 12'h00F, s: 0, e: 0, f: 15, sat: 0, lat: 9};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.D         = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_result", int'({bus.S, bus.E, bus.F, bus.sat}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].d, 0, 1'b0, lat);
      chk("vec_S", o_s, vecs[i].s);
      chk("vec_E", o_e, vecs[i].e);
      chk("vec_F", o_f, vecs[i].f);
      chk("vec_sat", o_sat, vecs[i].sat);
      chk("vec_latency", lat, vecs[i].lat);
    end

    // Backpressure with an ignored in_valid pulse while busy.
    run_txn(12'h1A6, 5, 1'b1, lat);
    chk("bp_E", o_e, 5);
    chk("bp_F", o_f, 13);
    @(posedge clk); #1;
    chk("bp_still_idle", int'(bus.busy), 0);
    chk("bp_no_late_valid", int'(bus.out_valid), 0);

    // Reset while normalising.
    bus.D = 12'h000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("norm_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    repeat (10) begin
      @(posedge clk); #1;
      chk("midrst_no_result", int'(bus.out_valid), 0);
    end
    run_txn(12'h040, 0, 1'b0, lat);
    chk("post_rst_S", o_s, 0);
    chk("post_rst_E", o_e, 3);
    chk("post_rst_F", o_f, 8);
    chk("post_rst_latency", lat, 6);

    for (int n = 0; n < 150; n++) begin
      d = 12'($urandom);
      if (n % 10 == 0) d = 12'h800;
      if (n % 10 == 5) d = 12'($urandom_range(0, 31));
      model(d, s, e, f, sat, lat);
      begin
        int got_lat;
        run_txn(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), got_lat);
        chk("rnd_S", o_s, s);
        chk("rnd_E", o_e, e);
        chk("rnd_F", o_f, f);
        chk("rnd_sat", o_sat, sat);
        chk("rnd_latency", got_lat, lat);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_seq_converter.md
Name: fp_seq_converter

Overview:
- Sequenced replacement for the lab's combinational 12-bit-to-floating-point converter.
- Accepts one 12-bit two's-complement sample per transaction over a valid/ready handshake.
- Normalises by serial left-shift, one bit per clock, then rounds using the first dropped bit and saturates on overflow.
- Sits between the switch/sample capture logic and the display driver. Result is held until the consumer accepts it.

Parameters:
- IN_W, 12, input sample width. Must equal SIG_W + 2**EXP_W.
- EXP_W, 3, exponent width.
- SIG_W, 4, significand width.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  D is valid
- in_ready  out  1  block can accept a sample
- D  in  IN_W  two's-complement sample
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- S  out  1  sign of the result
- E  out  EXP_W  exponent
- F  out  SIG_W  significand; value = F * 2^E
- sat  out  1  result was clamped to the maximum magnitude
- busy  out  1  state is not IDLE

Behaviour:

Reset:
- Applies when rst_n is low at a clk edge, including mid-operation.
- State goes to IDLE and any in-flight sample is discarded.
- Outputs: out_valid=0, S=0, E=0, F=0, sat=0, busy=0, in_ready=1.

States: IDLE, NORM, ROUND, DONE.

IDLE:
- in_ready=1.
- When in_valid=1, on that edge: capture S=D[11], mag=|D| (lower 11 bits), exp=7, and ovf=(D==0x800). Go to NORM.

NORM (one cycle per step):
- If ovf, or mag[10]=1, or exp==0: go to ROUND.
- Otherwise: mag <= mag<<1, exp <= exp-1, stay in NORM.

ROUND:
- f = mag[10:7], fifth = mag[6]. If exp==0 then fifth=0 (automatically true by the shifting).
- If ovf: E=7, F=15, sat=1.
- Else if fifth=1 and f==15:
  - exp<7: F=8, E=exp+1, sat=0.
  - exp==7: F=15, E=7, sat=1.
- Else: F = f+fifth, E = exp, sat=0.
- Go to DONE.

DONE:
- out_valid=1. S/E/F/sat are held stable while out_ready=0.
- When out_ready=1: out_valid drops on that edge and the state goes to IDLE.

Handshake and timing:
- in_ready=1 only in IDLE. in_valid seen in any other state is ignored (not queued).
- Latency: out_valid rises k+2 clocks after the accept edge, where k = number of shifts (0..7). Range is 2 to 9.
- Minimum transaction period is k+4 clocks.
- Zero input: 7 shifts, result S=0 E=0 F=0.
- Negative zero cannot occur.
- Unsigned comparisons and arithmetic throughout. exp never underflows because the exp==0 check comes first.

Decomposition:
- Package fp_conv_pkg:
  - State encoding: IDLE=2'd0, NORM=2'd1, ROUND=2'd2, DONE=2'd3.
  - IN_W/EXP_W/SIG_W defaults.
  - Constants EXP_MAX=7, SIG_MAX=15, MIN_NEG=12'h800.
- One sub-module, fp_round: purely combinational. Inputs f, fifth, exp, ovf; outputs E, F, sat. Instantiated for ROUND.
- Top holds the FSM, the mag/exp/sign registers and the handshake.

Test Plan:
- D=0x1A6 (422) -> S=0 E=5 F=13 sat=0, out_valid 4 clk after accept.
- D=0xFC8 (-56) -> S=1 E=2 F=14 sat=0, latency 7. D=0x000 -> S=0 E=0 F=0, latency 9.
- D=0x3FF (1023) -> round carry: S=0 E=7 F=8 sat=0, latency 3. D=0x7FF (2047) -> S=0 E=7 F=15 sat=1, latency 2.
- D=0x800 (-2048) -> S=1 E=7 F=15 sat=1, latency 2. D=0x00F -> S=0 E=0 F=15 sat=0, no rounding.
- Backpressure: out_ready=0 for 5 clk in DONE -> outputs stable, in_ready=0. A pulse of in_valid with D=0x123 during busy is ignored. Then out_ready=1 -> IDLE on the next edge.
- rst_n=0 for 1 clk while in NORM -> next state IDLE, out_valid=0, in_ready=1. A following sample D=0x040 (64) -> S=0 E=3 F=8.
